traffic_generator: RTL and testbench
====================================

Name: traffic_generator

Overview:
- Testbench traffic source at the enqueue side of the PIFO under test; counterpart of the dequeue-side traffic receiver.
- During a send phase, injects packets at an LFSR-gated injection rate, each carrying a generated flow ID and priority.
- Holds each offered packet until the PIFO accepts it and stops after a per-phase packet budget.
- Reports packets sent, stall cycles and phase completion to the bench controller.

Parameters:
- NUM_FLOWS, 16, number of flows; must be a power of two.
- CNT_BITS, 32, width of the statistics counters and of the packet budget.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset; asserted when 0.
- i__config  in  TGConfig  injrate, injrate_seed, flow_seed, prio_seed, flow_mode, prio_base, prio_mask, num_packets.
- i__send_phase  in  1  high while the bench is in the send phase.
- i__pifo_ready  in  1  PIFO can accept an enqueue this cycle.
- o__enqueue  out  1  valid: a packet is offered.
- o__packet_flow_id  out  FlowId  flow of the offered packet.
- o__packet_priority  out  Priority  rank of the offered packet.
- o__num_pkts_sent  out  CNT_BITS  accepted packets this phase.
- o__stall_cycles  out  CNT_BITS  cycles with o__enqueue=1 and i__pifo_ready=0.
- o__done  out  1  phase complete.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - o__enqueue, flow ID, priority, both counters and o__done are all 0.
  - LFSRs are loaded with their seeds.
- States IDLE, SEND, DRAIN, DONE.
- IDLE:
  - Goes to SEND when i__send_phase=1.
  - On that edge, i__config is registered and the counters are cleared.
  - Config changes during a phase are ignored.
- Handshake:
  - Transfer occurs in a cycle with o__enqueue=1 and i__pifo_ready=1.
  - While o__enqueue=1 and there is no transfer, flow ID and priority stay stable.
  - An offered packet is never retracted.
- Injection decision, made in SEND only:
  - Inject when budget remains, the slot is empty or transferring this cycle, and lfsr_inj < injrate.
  - The injection LFSR advances every SEND cycle.
  - A decision in cycle t gives o__enqueue=1 in cycle t+1. Back-to-back packets are allowed.
  - injrate=0 never injects. injrate=all-ones injects on every LFSR state except the all-ones one.
- Flow ID:
  - flow_mode=0: round-robin starting at 0, wrapping NUM_FLOWS-1 to 0.
  - flow_mode=1: lfsr_flow & (NUM_FLOWS-1).
  - The flow LFSR advances only on an injection decision.
- Priority:
  - prio = prio_base + (lfsr_prio & prio_mask), modulo 2^$bits(Priority); overflow wraps silently.
  - The priority LFSR advances only on an injection decision.
- Budget:
  - "Remaining" counts accepted plus pending packets against num_packets.
  - num_packets=0 means unlimited.
- Transitions from SEND:
  - i__send_phase=0 goes to DRAIN if a packet is pending, otherwise DONE.
  - Budget exhausted goes to DRAIN if a packet is pending, otherwise DONE.
- DRAIN:
  - No new decisions.
  - Goes to DONE in the cycle after the pending packet transfers.
- DONE:
  - o__done=1; counters hold.
  - Goes to IDLE when i__send_phase=0.
  - If i__send_phase is still 1, stay in DONE; a new phase requires a 0→1 transition.
- Counters:
  - o__num_pkts_sent increments on transfer.
  - o__stall_cycles increments on offered-but-not-ready cycles.
  - Both saturate at all-ones.
- Reset asserted mid-operation: immediate return to the reset values. A pending packet is dropped and not counted.

Decomposition:
- Shared testbench header/package holds:
  - TGConfig struct.
  - InjectionRate, FlowId, Priority and CounterSignal typedefs.
  - TG state enum.
  - FLOW_MODE_RR/FLOW_MODE_LFSR constants.
- Sub-module: three instances of linear_feedback_shift_register for injection, flow and priority.
  - Widths are $bits(InjectionRate), $bits(FlowId) and $bits(Priority).
  - Seed inputs come from the registered config; next inputs are as defined above.

Test Plan:
- Full rate: injrate=all-ones, num_packets=8, ready=1 → 8 transfers, o__done=1, o__num_pkts_sent=8, o__stall_cycles=0; round-robin flow IDs 0..7.
- Backpressure: ready=0 for 5 cycles after the first offer, then 1 → flow ID and priority stable for 5 cycles, o__stall_cycles=5, no packet lost or duplicated.
- Early phase end: i__send_phase drops with a packet pending and ready=0 for 3 cycles → DRAIN; one transfer, then o__done; no new offers.
- Rate 0 and budget wrap: injrate=0 for 100 cycles → o__enqueue never 1; NUM_FLOWS=16 with 20 packets → flows 0..15,0..3.
- Priority wrap: prio_base=0xFFF0, prio_mask=0x00FF, 16-bit Priority → every priority equals (0xFFF0+masked LFSR) mod 2^16 against a reference model.
- Async reset mid-SEND with a pending offer → o__enqueue=0 immediately; counters=0; a new phase replays an identical packet sequence (same seeds).

Source files
------------

// File: rtl/traffic_generator_pkg.sv
// Shared types for the PIFO enqueue-side traffic generator: config record,
// field typedefs, state encoding and LFSR tap selection.
package traffic_generator_pkg;

    localparam int INJ_BITS  = 8;
    localparam int FLOW_BITS = 8;
    localparam int PRIO_BITS = 16;
    localparam int CNT_W     = 32;

    typedef logic [INJ_BITS-1:0]  InjectionRate;
    typedef logic [FLOW_BITS-1:0] FlowId;
    typedef logic [PRIO_BITS-1:0] Priority;
    typedef logic [CNT_W-1:0]     CounterSignal;

    localparam logic FLOW_MODE_RR   = 1'b0;
    localparam logic FLOW_MODE_LFSR = 1'b1;

    typedef enum logic [1:0] {
        TG_IDLE,
        TG_SEND,
        TG_DRAIN,
        TG_DONE
    } tg_state_e;

    typedef struct packed {
        InjectionRate injrate;
        InjectionRate injrate_seed;
        FlowId        flow_seed;
        Priority      prio_seed;
        logic         flow_mode;
        Priority      prio_base;
        Priority      prio_mask;
        CounterSignal num_packets;
    } TGConfig;

    // Right-shifting Galois masks giving maximal-length sequences.
    function automatic logic [31:0] lfsr_taps(input int width);
        case (width)
            3:       return 32'h0000_0006;
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            16:      return 32'h0000_B400;
            32:      return 32'h8020_0003;
            default: return (32'h1 << (width - 1)) | 32'h1;
        endcase
    endfunction

endpackage

// File: rtl/traffic_generator_lfsr.sv
// Galois LFSR with synchronous seed load and step enable; an all-zero seed
// is replaced by 1 so the register can never lock up.
module linear_feedback_shift_register
    import traffic_generator_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             next,
    output logic [WIDTH-1:0] value
);

    localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] state_reg;
    logic [WIDTH-1:0] seed_fixed;
    logic [WIDTH-1:0] stepped;

    assign seed_fixed = (seed == '0) ? ONE : seed;
    assign stepped    = state_reg[0] ? ((state_reg >> 1) ^ TAPS) : (state_reg >> 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ONE;
        end else if (load) begin
            state_reg <= seed_fixed;
        end else if (next) begin
            state_reg <= stepped;
        end
    end

    assign value = state_reg;

endmodule

// File: rtl/traffic_generator.sv
// Enqueue-side traffic source: offers LFSR-paced packets to the PIFO, holds each
// offer until accepted, enforces a per-phase budget and keeps statistics.
module traffic_generator
    import traffic_generator_pkg::*;
#(
    parameter int NUM_FLOWS = 16,
    parameter int CNT_BITS  = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  TGConfig             i__config,
    input  logic                i__send_phase,
    input  logic                i__pifo_ready,
    output logic                o__enqueue,
    output FlowId               o__packet_flow_id,
    output Priority             o__packet_priority,
    output logic [CNT_BITS-1:0] o__num_pkts_sent,
    output logic [CNT_BITS-1:0] o__stall_cycles,
    output logic                o__done
);

    localparam FlowId               FLOW_MASK = FlowId'(NUM_FLOWS - 1);
    localparam logic [CNT_BITS-1:0] CNT_MAX   = '1;

    tg_state_e           state_reg, state_next;
    TGConfig             config_reg, config_next;
    logic                valid_reg, valid_next;
    FlowId               flow_reg, flow_next;
    Priority             prio_reg, prio_next;
    FlowId               rr_reg, rr_next;
    logic [CNT_BITS-1:0] sent_reg, sent_next;
    logic [CNT_BITS-1:0] stall_reg, stall_next;

    InjectionRate        lfsr_inj;
    FlowId               lfsr_flow;
    Priority             lfsr_prio;

    logic                transfer;
    logic                inject;
    logic                unlimited;
    logic                budget_left;
    logic                exhausted;
    logic [CNT_BITS-1:0] budget;
    logic [CNT_BITS:0]   committed;
    logic [CNT_BITS:0]   committed_after;

    assign transfer  = valid_reg & i__pifo_ready;
    assign budget    = CNT_BITS'(config_reg.num_packets);
    assign unlimited = (budget == '0);

    // Accepted plus pending packets; a transfer moves one from pending to accepted.
    assign committed       = {1'b0, sent_reg} + (CNT_BITS + 1)'(valid_reg);
    assign budget_left     = unlimited || (committed < {1'b0, budget});
    assign inject          = (state_reg == TG_SEND) && i__send_phase && budget_left
                             && (!valid_reg || transfer) && (lfsr_inj < config_reg.injrate);
    assign committed_after = committed + (CNT_BITS + 1)'(inject);
    assign exhausted       = !unlimited && (committed_after >= {1'b0, budget});

    always_comb begin
        state_next  = state_reg;
        config_next = config_reg;
        valid_next  = valid_reg;
        flow_next   = flow_reg;
        prio_next   = prio_reg;
        rr_next     = rr_reg;
        sent_next   = sent_reg;
        stall_next  = stall_reg;

        if (transfer) begin
            valid_next = 1'b0;
            if (sent_reg != CNT_MAX) sent_next = sent_reg + 1'b1;
        end
        if (valid_reg && !i__pifo_ready && (stall_reg != CNT_MAX)) begin
            stall_next = stall_reg + 1'b1;
        end
        if (inject) begin
            valid_next = 1'b1;
            flow_next  = (config_reg.flow_mode == FLOW_MODE_RR) ? rr_reg : (lfsr_flow & FLOW_MASK);
            prio_next  = config_reg.prio_base + (lfsr_prio & config_reg.prio_mask);
            rr_next    = (rr_reg == FLOW_MASK) ? '0 : rr_reg + 1'b1;
        end

        case (state_reg)
            TG_IDLE: begin
                config_next = i__config;
                if (i__send_phase) begin
                    state_next = TG_SEND;
                    sent_next  = '0;
                    stall_next = '0;
                    rr_next    = '0;
                end
            end
            TG_SEND: begin
                if (!i__send_phase || exhausted) begin
                    state_next = valid_next ? TG_DRAIN : TG_DONE;
                end
            end
            TG_DRAIN: begin
                if (transfer) state_next = TG_DONE;
            end
            TG_DONE: begin
                if (!i__send_phase) state_next = TG_IDLE;
            end
            default: state_next = TG_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= TG_IDLE;
            config_reg <= '0;
            valid_reg  <= 1'b0;
            flow_reg   <= '0;
            prio_reg   <= '0;
            rr_reg     <= '0;
            sent_reg   <= '0;
            stall_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            config_reg <= config_next;
            valid_reg  <= valid_next;
            flow_reg   <= flow_next;
            prio_reg   <= prio_next;
            rr_reg     <= rr_next;
            sent_reg   <= sent_next;
            stall_reg  <= stall_next;
        end
    end

    // Seeds reload every IDLE cycle so a new phase always replays from its seeds.
    linear_feedback_shift_register #(.WIDTH($bits(InjectionRate))) u_lfsr_inj (
        .clk   (clk),
        .reset (reset),
        .load  (state_reg == TG_IDLE),
        .seed  (config_next.injrate_seed),
        .next  (state_reg == TG_SEND),
        .value (lfsr_inj)
    );

    linear_feedback_shift_register #(.WIDTH($bits(FlowId))) u_lfsr_flow (
        .clk   (clk),
        .reset (reset),
        .load  (state_reg == TG_IDLE),
        .seed  (config_next.flow_seed),
        .next  (inject),
        .value (lfsr_flow)
    );

    linear_feedback_shift_register #(.WIDTH($bits(Priority))) u_lfsr_prio (
        .clk   (clk),
        .reset (reset),
        .load  (state_reg == TG_IDLE),
        .seed  (config_next.prio_seed),
        .next  (inject),
        .value (lfsr_prio)
    );

    assign o__enqueue         = valid_reg;
    assign o__packet_flow_id  = flow_reg;
    assign o__packet_priority = prio_reg;
    assign o__num_pkts_sent   = sent_reg;
    assign o__stall_cycles    = stall_reg;
    assign o__done            = (state_reg == TG_DONE);

endmodule

// File: tb/tb_traffic_generator.sv
// Directed bench for traffic_generator: table of full phases checked against a
// flow/priority reference model, plus hand sequences for stalls, drain, rate 0 and reset.
`timescale 1ns/1ps
module tb_traffic_generator;
    import traffic_generator_pkg::*;

    logic        clk;
    logic        reset;
    TGConfig     cfg;
    logic        send_phase;
    logic        pifo_ready;
    logic        enqueue;
    FlowId       flow_id;
    Priority     prio;
    logic [31:0] sent;
    logic [31:0] stall;
    logic        done;

    traffic_generator #(.NUM_FLOWS(16), .CNT_BITS(32)) dut (
        .clk                (clk),
        .reset              (reset),
        .i__config          (cfg),
        .i__send_phase      (send_phase),
        .i__pifo_ready      (pifo_ready),
        .o__enqueue         (enqueue),
        .o__packet_flow_id  (flow_id),
        .o__packet_priority (prio),
        .o__num_pkts_sent   (sent),
        .o__stall_cycles    (stall),
        .o__done            (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  m_flow;
    logic [15:0] m_prio;
    int          m_k;

    typedef struct {
        logic [7:0]  injrate;
        logic [7:0]  inj_seed;
        logic [7:0]  flow_seed;
        logic [15:0] prio_seed;
        logic        mode;
        logic [15:0] base;
        logic [15:0] mask;
        int          num;
        int          exp_sent;
        int          exp_stall;
    } vec_t;

    vec_t vecs [4];

    function automatic logic [7:0] step8(input logic [7:0] s);
        return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
    endfunction

    function automatic logic [15:0] step16(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_flow = (cfg.flow_seed == 8'h00) ? 8'h01 : cfg.flow_seed;
        m_prio = (cfg.prio_seed == 16'h0000) ? 16'h0001 : cfg.prio_seed;
        m_k    = 0;
    endtask

    task automatic check_transfer();
        logic [7:0]  exp_flow;
        logic [15:0] exp_prio;
        exp_flow = (cfg.flow_mode == FLOW_MODE_RR) ? 8'(m_k % 16) : (m_flow & 8'h0F);
        exp_prio = cfg.prio_base + (m_prio & cfg.prio_mask);
        $display("pkt %0d: flow %0d prio 0x%04h (model flow %0d prio 0x%04h)",
                 m_k, flow_id, prio, exp_flow, exp_prio);
        check("flow_id", 32'(flow_id), 32'(exp_flow));
        check("priority", 32'(prio), 32'(exp_prio));
        m_flow = step8(m_flow);
        m_prio = step16(m_prio);
        m_k++;
    endtask

    task automatic start_phase();
        send_phase = 1'b0;
        tick();
        tick();
        send_phase = 1'b1;
        model_reset();
        tick();
    endtask

    task automatic collect(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < max_cycles; c++) begin
            if (enqueue && pifo_ready) check_transfer();
            if (done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_offer(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < max_cycles; c++) begin
            if (enqueue) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic set_cfg(input vec_t v);
        cfg              = '0;
        cfg.injrate      = v.injrate;
        cfg.injrate_seed = v.inj_seed;
        cfg.flow_seed    = v.flow_seed;
        cfg.prio_seed    = v.prio_seed;
        cfg.flow_mode    = v.mode;
        cfg.prio_base    = v.base;
        cfg.prio_mask    = v.mask;
        cfg.num_packets  = 32'(v.num);
    endtask

    initial begin
        bit      ok;
        int      offers;
        FlowId   f0;
        Priority p0;
        vec_t    hv;

        // injrate, inj_seed, flow_seed, prio_seed, mode, base, mask, num, exp_sent, exp_stall
        vecs[0] = '{8'hFF, 8'h01, 8'h11, 16'h1234, 1'b0, 16'h0000, 16'hFFFF, 8,  8,  0};
        vecs[1] = '{8'h80, 8'h5A, 8'h33, 16'hBEEF, 1'b0, 16'h0010, 16'h003F, 20, 20, 0};
        vecs[2] = '{8'hC0, 8'h77, 8'h9D, 16'h0F0F, 1'b1, 16'h0100, 16'h000F, 10, 10, 0};
        vecs[3] = '{8'hFF, 8'h2C, 8'h42, 16'hACE1, 1'b1, 16'hFFF0, 16'h00FF, 12, 12, 0};

        reset      = 1'b0;
        cfg        = '0;
        send_phase = 1'b0;
        pifo_ready = 1'b0;
        #1;
        check("reset_enqueue", 32'(enqueue), 32'd0);
        check("reset_flow", 32'(flow_id), 32'd0);
        check("reset_prio", 32'(prio), 32'd0);
        check("reset_sent", sent, 32'd0);
        check("reset_stall", stall, 32'd0);
        check("reset_done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #4 reset = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) begin
            $display("vector %0d: injrate 0x%02h num %0d mode %0d", i, vecs[i].injrate, vecs[i].num, vecs[i].mode);
            set_cfg(vecs[i]);
            pifo_ready = 1'b1;
            start_phase();
            collect(3000, ok);
            check("phase_timeout", 32'(ok), 32'd1);
            check("pkts_observed", 32'(m_k), 32'(vecs[i].exp_sent));
            tick();
            check("done_holds", 32'(done), 32'd1);
            check("num_pkts_sent", sent, 32'(vecs[i].exp_sent));
            check("stall_cycles", stall, 32'(vecs[i].exp_stall));
            check("no_offer_after_done", 32'(enqueue), 32'd0);
        end

        // Backpressure: ready low for the first five offered cycles.
        hv = '{8'hFF, 8'h03, 8'h21, 16'h5555, 1'b0, 16'h0000, 16'hFFFF, 4, 4, 5};
        set_cfg(hv);
        pifo_ready = 1'b0;
        start_phase();
        wait_offer(50, ok);
        check("bp_first_offer", 32'(ok), 32'd1);
        f0 = flow_id;
        p0 = prio;
        for (int c = 0; c < 5; c++) begin
            $display("stall cycle %0d: enqueue %0d flow %0d prio 0x%04h", c, enqueue, flow_id, prio);
            check("bp_enqueue_held", 32'(enqueue), 32'd1);
            check("bp_flow_stable", 32'(flow_id), 32'(f0));
            check("bp_prio_stable", 32'(prio), 32'(p0));
            tick();
        end
        pifo_ready = 1'b1;
        collect(500, ok);
        check("bp_timeout", 32'(ok), 32'd1);
        check("bp_sent", sent, 32'd4);
        check("bp_observed", 32'(m_k), 32'd4);
        check("bp_stall", stall, 32'd5);

        // Early phase end with a pending packet held off for three cycles.
        hv = '{8'hFF, 8'h09, 8'h44, 16'h7001, 1'b0, 16'h0000, 16'h00FF, 0, 1, 3};
        set_cfg(hv);
        pifo_ready = 1'b0;
        start_phase();
        wait_offer(50, ok);
        check("early_first_offer", 32'(ok), 32'd1);
        send_phase = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("early_enqueue_held", 32'(enqueue), 32'd1);
            check("early_not_done", 32'(done), 32'd0);
            tick();
        end
        pifo_ready = 1'b1;
        check("early_enqueue_last", 32'(enqueue), 32'd1);
        check_transfer();
        tick();
        check("early_done", 32'(done), 32'd1);
        check("early_no_new_offer", 32'(enqueue), 32'd0);
        check("early_sent", sent, 32'd1);
        check("early_stall", stall, 32'd3);
        tick();
        check("early_back_to_idle", 32'(done), 32'd0);
        check("early_idle_no_offer", 32'(enqueue), 32'd0);

        // Injection rate zero never offers.
        hv = '{8'h00, 8'h01, 8'h01, 16'h0001, 1'b0, 16'h0000, 16'hFFFF, 0, 0, 0};
        set_cfg(hv);
        pifo_ready = 1'b1;
        start_phase();
        offers = 0;
        for (int c = 0; c < 100; c++) begin
            if (enqueue) offers++;
            tick();
        end
        $display("rate0: %0d offers in 100 cycles", offers);
        check("rate0_offers", 32'(offers), 32'd0);
        send_phase = 1'b0;
        tick();
        check("rate0_done", 32'(done), 32'd1);
        check("rate0_sent", sent, 32'd0);

        // Asynchronous reset while an offer is pending, then a clean replay.
        hv = '{8'hFF, 8'h6B, 8'h1F, 16'h4321, 1'b1, 16'h0200, 16'h0FFF, 6, 6, 0};
        set_cfg(hv);
        pifo_ready = 1'b0;
        start_phase();
        wait_offer(50, ok);
        check("rst_first_offer", 32'(ok), 32'd1);
        tick();
        tick();
        #2 reset = 1'b0;
        #1;
        $display("async reset: enqueue %0d sent %0d stall %0d done %0d", enqueue, sent, stall, done);
        check("rst_enqueue", 32'(enqueue), 32'd0);
        check("rst_sent", sent, 32'd0);
        check("rst_stall", stall, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_flow", 32'(flow_id), 32'd0);
        send_phase = 1'b0;
        #1 reset = 1'b1;
        tick();
        pifo_ready = 1'b1;
        start_phase();
        collect(500, ok);
        check("replay_timeout", 32'(ok), 32'd1);
        check("replay_sent", sent, 32'd6);
        check("replay_observed", 32'(m_k), 32'd6);
        check("replay_stall", stall, 32'd0);

        send_phase = 1'b0;
        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running required finished");
        $fatal(1, "timeout");
    end

endmodule
